scalar_mult_requester: RTL and testbench

Initiator-side sequencer for the `scalar_multiplication` core (255-bit x-only Curve25519 ladder). It accepts scalar/point requests over a valid/ready handshake and optionally clamps the scalar. It drives the core's operand and reset pins, waits for `done`, and returns `x_q` with a measured cycle count or a timeout flag over a second valid/ready handshake. It sits between the system request bus and one `scalar_multiplication` instance, replacing bench-style reset-then-wait control.

---
 rtl/scalar_mult_requester_pkg.sv | 24 ++
 rtl/scalar_mult_requester.sv | 110 +++++++++++
 tb/tb_scalar_mult_requester.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_mult_requester_pkg.sv
// Shared widths, sequencer state encoding and scalar clamping for the
// scalar_multiplication requester and future X25519 wrappers.
package scalar_mult_requester_pkg;

  localparam int FIELD_W = 255;
  localparam int CYCLE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  // X25519 clamp: clear the cofactor bits and force the top bit.
  function automatic logic [FIELD_W-1:0] clamp_scalar(input logic [FIELD_W-1:0] k);
    logic [FIELD_W-1:0] r;
    r            = k;
    r[2:0]       = 3'b000;
    r[FIELD_W-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/scalar_mult_requester.sv
// Request/response sequencer around one scalar_multiplication core: loads
// operands, pulses the core reset, waits for done or a timeout, returns x_q.
module scalar_mult_requester
  import scalar_mult_requester_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000000,
  parameter bit CLAMP      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FIELD_W-1:0] req_k,
  input  logic [FIELD_W-1:0] req_x,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [FIELD_W-1:0] rsp_x,
  output logic [CYCLE_W-1:0] rsp_cycles,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [FIELD_W-1:0] core_k,
  output logic [FIELD_W-1:0] core_x_p,
  output logic               core_rst,
  input  logic [FIELD_W-1:0] core_x_q,
  input  logic               core_done
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CNT_LAST = CYCLE_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [RST_W-1:0]   r_rst_cnt;
  logic [CYCLE_W-1:0] r_cnt;
  logic [FIELD_W-1:0] r_core_k;
  logic [FIELD_W-1:0] r_core_x_p;
  logic [FIELD_W-1:0] r_rsp_x;
  logic [CYCLE_W-1:0] r_rsp_cycles;
  logic               r_rsp_timeout;
  logic [FIELD_W-1:0] w_k_in;

  assign w_k_in = CLAMP ? clamp_scalar(req_k) : req_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rst_cnt     <= '0;
      r_cnt         <= '0;
      r_core_k      <= '0;
      r_core_x_p    <= '0;
      r_rsp_x       <= '0;
      r_rsp_cycles  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_core_k   <= w_k_in;
            r_core_x_p <= req_x;
            r_rst_cnt  <= '0;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (r_rst_cnt == RST_LAST) begin
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
          end
        end
        RUN: begin
          // done wins over timeout when both land on the last allowed cycle
          if (core_done) begin
            r_rsp_x       <= core_x_q;
            r_rsp_cycles  <= r_cnt;
            r_rsp_timeout <= 1'b0;
            r_state       <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_x       <= '0;
            r_rsp_cycles  <= CYCLE_W'(TIMEOUT);
            r_rsp_timeout <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_cnt <= r_cnt + CYCLE_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state so an async reset takes effect immediately.
  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign busy        = (r_state == LOAD) || (r_state == RUN);
  assign core_rst    = (r_state != RUN);
  assign core_k      = r_core_k;
  assign core_x_p    = r_core_x_p;
  assign rsp_x       = r_rsp_x;
  assign rsp_cycles  = r_rsp_cycles;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_scalar_mult_requester.sv
// Self-checking bench: two requester configurations, each driving a behavioural
// core stub, checked every cycle against a timeline model of the request flow.
module tb_scalar_mult_requester;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;
  bit done_f [2];

  task automatic chk(input string nm, input int inst, input logic [254:0] act, input logic [254:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL inst%0d %s at cycle %0d: got %h expected %h", inst, nm, cyc, act, exp);
    end
  endtask

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[254:0];
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int RC = (gi == 0) ? 2 : 3;
    localparam bit CL = (gi == 0);
    localparam logic [254:0] K7 = CL ? {1'b1, 254'h0} : 255'h7;

    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [254:0] req_k = '0;
    logic [254:0] req_x = '0;
    logic         req_ready, rsp_valid, rsp_timeout, busy, core_rst, core_done;
    logic [254:0] rsp_x, core_k, core_x_p, core_x_q;
    logic [31:0]  rsp_cycles;

    scalar_mult_requester #(
      .RST_CYCLES(RC),
      .TIMEOUT   (TO),
      .CLAMP     (CL)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_k      (req_k),
      .req_x      (req_x),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_x      (rsp_x),
      .rsp_cycles (rsp_cycles),
      .rsp_timeout(rsp_timeout),
      .busy       (busy),
      .core_k     (core_k),
      .core_x_p   (core_x_p),
      .core_rst   (core_rst),
      .core_x_q   (core_x_q),
      .core_done  (core_done)
    );

    // Core stub: done on the N-th cycle after reset release; stale mode
    // holds done high whenever the core is in reset.
    int scnt = 0;
    int stub_n = 0;
    bit stale = 1'b0;
    always @(posedge clk) scnt <= core_rst ? 0 : scnt + 1;
    assign core_done = (stale && core_rst) || (!core_rst && (scnt == stub_n));
    assign core_x_q  = core_k ^ core_x_p;

    // Timeline model: after acceptance edge T, LOAD spans RC cycles, RUN
    // spans N+1 cycles (or TO on timeout), then RESP until rsp_ready.
    bit           m_act = 1'b0;
    int           t_run, t_resp, e_cyc;
    logic [254:0] e_k, e_xp, e_x;
    bit           e_to;

    always @(negedge clk) begin
      if (rst) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        chk("idle_req_ready", gi, req_ready, 1);
        chk("idle_busy", gi, busy, 0);
        chk("idle_rsp_valid", gi, rsp_valid, 0);
        chk("idle_core_rst", gi, core_rst, 1);
        if (req_valid) begin
          m_act  = 1'b1;
          t_run  = cyc + 1 + RC;
          e_k    = CL ? ((req_k & ~255'h7) | (255'h1 << 254)) : req_k;
          e_xp   = req_x;
          if (stub_n < TO) begin
            t_resp = t_run + stub_n + 1;
            e_x    = e_k ^ req_x;
            e_cyc  = stub_n;
            e_to   = 1'b0;
          end else begin
            t_resp = t_run + TO;
            e_x    = '0;
            e_cyc  = TO;
            e_to   = 1'b1;
          end
        end
      end else if (cyc < t_resp) begin
        chk("busy_req_ready", gi, req_ready, 0);
        chk("busy_busy", gi, busy, 1);
        chk("busy_rsp_valid", gi, rsp_valid, 0);
        chk("busy_core_rst", gi, core_rst, (cyc < t_run));
        chk("busy_core_k", gi, core_k, e_k);
        chk("busy_core_x_p", gi, core_x_p, e_xp);
      end else begin
        chk("resp_req_ready", gi, req_ready, 0);
        chk("resp_busy", gi, busy, 0);
        chk("resp_rsp_valid", gi, rsp_valid, 1);
        chk("resp_core_rst", gi, core_rst, 1);
        chk("resp_rsp_x", gi, rsp_x, e_x);
        chk("resp_rsp_cycles", gi, rsp_cycles, e_cyc);
        chk("resp_rsp_timeout", gi, rsp_timeout, e_to);
        if (rsp_ready) m_act = 1'b0;
      end
    end

    logic [254:0] rx;
    int           rc, acc_cyc, rise_cyc, resp_cyc, n;
    bit           rt;

    // Called just after a rising edge; leaves just after the acceptance edge.
    task automatic send(input logic [254:0] k, input logic [254:0] x, input int nn, input bit st);
      bit ok = 1'b0;
      stub_n = nn; stale = st; req_k = k; req_x = x; req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (req_ready) begin ok = 1'b1; break; end
      end
      chk("req_accepted", gi, ok, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc_cyc   = cyc;
    endtask

    // d = cycles of backpressure after rsp_valid rises (0 = ready up front).
    task automatic recv(input int d);
      bit seen = 1'b0;
      rsp_ready = (d == 0);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rsp_valid) begin seen = 1'b1; break; end
      end
      rise_cyc = cyc;
      chk("rsp_seen", gi, seen, 1);
      if (d > 0) begin
        repeat (d) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
      end
      rx = rsp_x; rc = rsp_cycles; rt = rsp_timeout;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      resp_cyc  = cyc;
    endtask

    initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", gi, req_ready, 1);
      chk("rst_rsp_valid", gi, rsp_valid, 0);
      chk("rst_busy", gi, busy, 0);
      chk("rst_core_rst", gi, core_rst, 1);
      chk("rst_core_k", gi, core_k, 0);
      chk("rst_rsp_cycles", gi, rsp_cycles, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      send(255'h7, 255'h5, 10, 1'b0);
      chk("lit_core_k", gi, core_k, K7);
      recv(0);
      chk("lit_rsp_x", gi, rx, K7 ^ 255'h5);
      chk("lit_rsp_cycles", gi, rc, 10);
      chk("lit_rsp_timeout", gi, rt, 0);
      chk("lit_latency", gi, rise_cyc - acc_cyc, RC + 11);

      send(255'h7, 255'h3, 4, 1'b0);
      chk("lit_b2b_gap", gi, acc_cyc - resp_cyc, 1);
      recv(0);
      chk("lit_b2b_rsp_x", gi, rx, K7 ^ 255'h3);

      send(rnd255(), rnd255(), 255, 1'b0);
      recv(2);
      chk("lit_to_rsp_x", gi, rx, 0);
      chk("lit_to_cycles", gi, rc, TO);
      chk("lit_to_flag", gi, rt, 1);
      chk("lit_to_latency", gi, rise_cyc - acc_cyc, RC + TO);

      send(rnd255(), rnd255(), TO - 1, 1'b0);
      recv(1);
      chk("lit_edge_cycles", gi, rc, TO - 1);
      chk("lit_edge_flag", gi, rt, 0);

      send(rnd255(), rnd255(), 0, 1'b0);
      recv(0);
      chk("lit_zero_cycles", gi, rc, 0);

      send(rnd255(), rnd255(), 3, 1'b0);
      recv(20);
      chk("lit_bp_cycles", gi, rc, 3);

      send(rnd255(), rnd255(), 10, 1'b0);
      repeat (RC + 5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_req_ready", gi, req_ready, 1);
      chk("mid_rsp_valid", gi, rsp_valid, 0);
      chk("mid_busy", gi, busy, 0);
      chk("mid_core_rst", gi, core_rst, 1);
      chk("mid_core_k", gi, core_k, 0);
      chk("mid_core_x_p", gi, core_x_p, 0);
      chk("mid_rsp_x", gi, rsp_x, 0);
      chk("mid_rsp_cycles", gi, rsp_cycles, 0);
      chk("mid_rsp_timeout", gi, rsp_timeout, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      send(255'h7, 255'h5, 10, 1'b0);
      recv(0);
      chk("lit_post_rst_cycles", gi, rc, 10);
      chk("lit_post_rst_rsp_x", gi, rx, K7 ^ 255'h5);

      send(rnd255(), rnd255(), 6, 1'b1);
      recv(0);
      chk("lit_stale_cycles", gi, rc, 6);

      for (int t = 0; t < 20; t++) begin
        n = $urandom_range(0, 20);
        send(rnd255(), rnd255(), n, 1'($urandom_range(0, 1)));
        recv($urandom_range(0, 3));
        chk("rand_cycles", gi, rc, (n < TO) ? n : TO);
      end
      done_f[gi] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk);
      if (done_f[0] && done_f[1]) break;
    end
    if (!(done_f[0] && done_f[1])) begin
      n_checks++;
      n_errs++;
      $display("FAIL sim_bound: stimulus did not complete, done=%0d/%0d", done_f[0], done_f[1]);
    end
    #2;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
